// File: rtl/snake_scene_gen.sv
// snake_scene_gen: stateful scene source for the grid display path.
// Holds snake, apple, map and game-over state and answers per-cell (x,y) queries combinationally.
module snake_scene_gen #(
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 12,
    parameter int COORD_W  = 4,
    parameter int MAX_LEN  = 8,
    parameter int NUM_MAPS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         map_btn,
    input  logic                         step,
    input  logic [1:0]                   dir,
    input  logic [COORD_W-1:0]           x,
    input  logic [COORD_W-1:0]           y,
    output logic                         border,
    output logic                         snake_head,
    output logic                         snake_body,
    output logic                         apple,
    output logic                         ready,
    output logic                         game_over,
    output logic [$clog2(NUM_MAPS)-1:0]  map_idx,
    output logic [$clog2(MAX_LEN+1)-1:0] length
);
    localparam int MAP_W = $clog2(NUM_MAPS);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int CW1   = COORD_W + 1;

    localparam logic [CW1-1:0]     GRID_W_C    = CW1'(GRID_W);
    localparam logic [CW1-1:0]     GRID_H_C    = CW1'(GRID_H);
    localparam logic [CW1-1:0]     X_LAST      = CW1'(GRID_W - 1);
    localparam logic [CW1-1:0]     Y_LAST      = CW1'(GRID_H - 1);
    localparam logic [CW1-1:0]     X_INNER_MAX = CW1'(GRID_W - 2);
    localparam logic [CW1-1:0]     Y_INNER_MAX = CW1'(GRID_H - 2);
    localparam logic [COORD_W-1:0] START_Y     = COORD_W'(GRID_H / 3);
    localparam logic [LEN_W-1:0]   LEN_START   = LEN_W'(3);
    localparam logic [LEN_W-1:0]   LEN_MAX     = LEN_W'(MAX_LEN);
    localparam logic [MAP_W-1:0]   MAP_LAST    = MAP_W'(NUM_MAPS - 1);
    localparam logic [15:0]        LFSR_SEED   = 16'hACE1;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'b00,
        ST_RUN   = 2'b01,
        ST_RELOC = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    state_t             state_q;
    logic [COORD_W-1:0] seg_x_q [MAX_LEN];
    logic [COORD_W-1:0] seg_y_q [MAX_LEN];
    logic [LEN_W-1:0]   len_q;
    logic [COORD_W-1:0] apple_x_q;
    logic [COORD_W-1:0] apple_y_q;
    logic [MAP_W-1:0]   map_q;
    logic               over_q;
    logic               ready_q;
    logic [1:0]         dir_q;
    logic [15:0]        lfsr_q;
    logic               btn_meta_q;
    logic               btn_sync_q;
    logic               btn_prev_q;

    logic [15:0]        lfsr_d;
    logic [MAP_W-1:0]   map_d;
    logic [LEN_W-1:0]   len_grow_d;
    logic               map_rise_s;
    logic [1:0]         eff_dir_s;
    logic [CW1-1:0]     head_nx_s;
    logic [CW1-1:0]     head_ny_s;
    logic               new_hit_s;
    logic               eat_s;
    logic [CW1-1:0]     cand_x_s;
    logic [CW1-1:0]     cand_y_s;
    logic               cand_hit_s;
    logic               cand_ok_s;
    logic               in_grid_s;
    logic               body_hit_s;

    // Start column of a map-k segment sitting `off` cells right of column k.
    function automatic logic [COORD_W-1:0] start_x(input logic [MAP_W-1:0] k,
                                                   input logic [COORD_W-1:0] off);
        return COORD_W'(k) + off;
    endfunction

    assign map_rise_s = btn_sync_q & ~btn_prev_q;
    assign lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign map_d      = (map_q == MAP_LAST) ? MAP_W'(0) : map_q + MAP_W'(1);
    assign len_grow_d = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);

    assign ready     = ready_q;
    assign game_over = over_q;
    assign map_idx   = map_q;
    assign length    = len_q;

    // Map button synchronizer plus delayed copy for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            btn_meta_q <= map_btn;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    // Free-running LFSR used as the apple placement source.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Step evaluation: effective direction, next head, collision and apple hit.
    always_comb begin
        eff_dir_s = (dir == (dir_q ^ 2'b01)) ? dir_q : dir;
        head_nx_s = {1'b0, seg_x_q[0]};
        head_ny_s = {1'b0, seg_y_q[0]};
        case (eff_dir_s)
            DIR_RIGHT: head_nx_s = {1'b0, seg_x_q[0]} + CW1'(1);
            DIR_LEFT:  head_nx_s = {1'b0, seg_x_q[0]} - CW1'(1);
            DIR_UP:    head_ny_s = {1'b0, seg_y_q[0]} - CW1'(1);
            DIR_DOWN:  head_ny_s = {1'b0, seg_y_q[0]} + CW1'(1);
            default:   head_nx_s = {1'b0, seg_x_q[0]};
        endcase
        // The old tail vacates this step, so only segments 0..length-2 can be hit.
        new_hit_s = (head_nx_s == CW1'(0)) || (head_nx_s >= X_LAST) ||
                    (head_ny_s == CW1'(0)) || (head_ny_s >= Y_LAST);
        for (int i = 0; i < MAX_LEN; i++) begin
            new_hit_s = new_hit_s | ((LEN_W'(i + 1) < len_q) &&
                                     (head_nx_s == {1'b0, seg_x_q[i]}) &&
                                     (head_ny_s == {1'b0, seg_y_q[i]}));
        end
        eat_s = (head_nx_s == {1'b0, apple_x_q}) && (head_ny_s == {1'b0, apple_y_q});
    end

    // Apple candidate from the LFSR; accepted only inside the border and off the snake.
    always_comb begin
        cand_x_s   = CW1'(lfsr_q[COORD_W-1:0]) + CW1'(1);
        cand_y_s   = CW1'(lfsr_q[2*COORD_W-1:COORD_W]) + CW1'(1);
        cand_hit_s = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            cand_hit_s = cand_hit_s | ((LEN_W'(i) < len_q) &&
                                       (cand_x_s == {1'b0, seg_x_q[i]}) &&
                                       (cand_y_s == {1'b0, seg_y_q[i]}));
        end
        cand_ok_s = (cand_x_s <= X_INNER_MAX) && (cand_y_s <= Y_INNER_MAX) && !cand_hit_s;
    end

    // Per-cell query answers; out-of-grid cells report border only.
    always_comb begin
        in_grid_s  = ({1'b0, x} < GRID_W_C) && ({1'b0, y} < GRID_H_C);
        body_hit_s = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            body_hit_s = body_hit_s | ((LEN_W'(i) < len_q) &&
                                       (seg_x_q[i] == x) && (seg_y_q[i] == y));
        end
        border     = !in_grid_s || (x == COORD_W'(0)) || ({1'b0, x} == X_LAST) ||
                     (y == COORD_W'(0)) || ({1'b0, y} == Y_LAST);
        snake_head = in_grid_s && (seg_x_q[0] == x) && (seg_y_q[0] == y);
        snake_body = in_grid_s && body_hit_s;
        apple      = in_grid_s && (apple_x_q == x) && (apple_y_q == y);
    end

    // Game FSM: load, run, apple relocation and game-over, with map change taking priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            ready_q   <= 1'b0;
            over_q    <= 1'b0;
            map_q     <= MAP_W'(0);
            dir_q     <= DIR_RIGHT;
            len_q     <= LEN_START;
            apple_x_q <= start_x(MAP_W'(0), COORD_W'(6));
            apple_y_q <= START_Y;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < 3) ? start_x(MAP_W'(0), COORD_W'(3 - i)) : COORD_W'(0);
                seg_y_q[i] <= (i < 3) ? START_Y : COORD_W'(0);
            end
        end else if (map_rise_s) begin
            map_q   <= map_d;
            over_q  <= 1'b0;
            ready_q <= 1'b0;
            state_q <= ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    dir_q     <= DIR_RIGHT;
                    len_q     <= LEN_START;
                    apple_x_q <= start_x(map_q, COORD_W'(6));
                    apple_y_q <= START_Y;
                    for (int i = 0; i < MAX_LEN; i++) begin
                        seg_x_q[i] <= (i < 3) ? start_x(map_q, COORD_W'(3 - i)) : COORD_W'(0);
                        seg_y_q[i] <= (i < 3) ? START_Y : COORD_W'(0);
                    end
                    over_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (step) begin
                        dir_q <= eff_dir_s;
                        if (new_hit_s) begin
                            over_q  <= 1'b1;
                            ready_q <= 1'b0;
                            state_q <= ST_OVER;
                        end else begin
                            seg_x_q[0] <= head_nx_s[COORD_W-1:0];
                            seg_y_q[0] <= head_ny_s[COORD_W-1:0];
                            for (int i = 1; i < MAX_LEN; i++) begin
                                seg_x_q[i] <= seg_x_q[i-1];
                                seg_y_q[i] <= seg_y_q[i-1];
                            end
                            // On growth the shifted-down old tail becomes the last active segment.
                            if (eat_s) begin
                                len_q   <= len_grow_d;
                                ready_q <= 1'b0;
                                state_q <= ST_RELOC;
                            end
                        end
                    end
                end
                ST_RELOC: begin
                    if (cand_ok_s) begin
                        apple_x_q <= cand_x_s[COORD_W-1:0];
                        apple_y_q <= cand_y_s[COORD_W-1:0];
                        ready_q   <= 1'b1;
                        state_q   <= ST_RUN;
                    end
                end
                ST_OVER: begin
                    ready_q <= 1'b0;
                    over_q  <= 1'b1;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snake_scene_gen.sv
// Self-checking bench for snake_scene_gen: directed scenarios plus steered random play
// compared against a queue-based game model.
module tb_snake_scene_gen;
    localparam int GW = 16;
    localparam int GH = 12;
    localparam int CW = 4;
    localparam int ML = 8;
    localparam int NM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          map_btn = 1'b0;
    logic          step = 1'b0;
    logic [1:0]    dir = 2'b00;
    logic [CW-1:0] x = '0;
    logic [CW-1:0] y = '0;
    logic          border, snake_head, snake_body, apple, ready, game_over;
    logic [1:0]    map_idx;
    logic [3:0]    length;

    snake_scene_gen #(.GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .MAX_LEN(ML), .NUM_MAPS(NM)) dut (
        .clk(clk), .reset(reset), .map_btn(map_btn), .step(step), .dir(dir), .x(x), .y(y),
        .border(border), .snake_head(snake_head), .snake_body(snake_body), .apple(apple),
        .ready(ready), .game_over(game_over), .map_idx(map_idx), .length(length)
    );

    always #50 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Game model: snake as a queue with the head at index 0.
    int          sx[$];
    int          sy[$];
    int          ax, ay, m_dir, m_map;
    bit          m_ready, m_over;
    logic [15:0] m_lfsr = 16'hACE1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic bit on_snake(input int cx, input int cy, input int n);
        for (int i = 0; i < n; i++)
            if (sx[i] == cx && sy[i] == cy) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_border(input int cx, input int cy);
        return (cx <= 0) || (cx >= GW - 1) || (cy <= 0) || (cy >= GH - 1);
    endfunction

    function automatic int eff_dir(input int d);
        return (d == (m_dir ^ 1)) ? m_dir : d;
    endfunction

    function automatic int dxo(input int d);
        return (d == 0) ? 1 : (d == 1) ? -1 : 0;
    endfunction

    function automatic int dyo(input int d);
        return (d == 2) ? -1 : (d == 3) ? 1 : 0;
    endfunction

    function automatic bit safe(input int d);
        int nd, nx, ny;
        nd = eff_dir(d);
        nx = sx[0] + dxo(nd);
        ny = sy[0] + dyo(nd);
        return !is_border(nx, ny) && !on_snake(nx, ny, sx.size() - 1);
    endfunction

    // Head toward the apple, occasionally taking a random (but survivable) turn.
    function automatic int pick_dir();
        int r;
        r = $urandom_range(0, 3);
        if ($urandom_range(0, 3) == 0 && safe(r)) return r;
        if (ax > sx[0] && safe(0)) return 0;
        if (ax < sx[0] && safe(1)) return 1;
        if (ay < sy[0] && safe(2)) return 2;
        if (ay > sy[0] && safe(3)) return 3;
        for (int d = 0; d < 4; d++)
            if (safe(d)) return d;
        return r;
    endfunction

    task automatic load_model(input int k);
        sx.delete();
        sy.delete();
        for (int i = 0; i < 3; i++) begin
            sx.push_back(3 + k - i);
            sy.push_back(GH / 3);
        end
        ax = 6 + k;
        ay = GH / 3;
        m_dir = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) m_lfsr = 16'hACE1;
        else m_lfsr = lfsr_next(m_lfsr);
        #1;
    endtask

    task automatic check_cell(input int cx, input int cy);
        bit in_g, eb, eh, ebody, eap;
        x = CW'(cx);
        y = CW'(cy);
        #1;
        in_g  = (cx < GW) && (cy < GH);
        eb    = !in_g || cx == 0 || cx == GW - 1 || cy == 0 || cy == GH - 1;
        eh    = in_g && cx == sx[0] && cy == sy[0];
        ebody = 1'b0;
        for (int i = 1; i < sx.size(); i++)
            if (in_g && sx[i] == cx && sy[i] == cy) ebody = 1'b1;
        eap   = in_g && cx == ax && cy == ay;
        chk($sformatf("border(%0d,%0d)", cx, cy), border, eb);
        chk($sformatf("snake_head(%0d,%0d)", cx, cy), snake_head, eh);
        chk($sformatf("snake_body(%0d,%0d)", cx, cy), snake_body, ebody);
        chk($sformatf("apple(%0d,%0d)", cx, cy), apple, eap);
    endtask

    task automatic check_state();
        chk("ready", ready, m_ready);
        chk("game_over", game_over, m_over);
        chk("map_idx", map_idx, m_map);
        chk("length", length, sx.size());
        for (int i = 0; i < sx.size(); i++) check_cell(sx[i], sy[i]);
        check_cell(ax, ay);
        for (int i = 0; i < 3; i++) check_cell($urandom_range(0, 15), $urandom_range(0, 15));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step = 1'b0;
        map_btn = 1'b0;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_map_idx", map_idx, 0);
        tick();
        tick();
        reset = 1'b0;
        m_map = 0;
        m_over = 1'b0;
        m_ready = 1'b0;
        load_model(0);
        chk("load_ready", ready, 0);
        tick();
        m_ready = 1'b1;
        check_state();
    endtask

    task automatic press_map(input bit with_step);
        map_btn = 1'b1;
        tick();
        tick();
        if (with_step) begin
            step = 1'b1;
            dir = 2'($urandom_range(0, 3));
        end
        tick();
        step = 1'b0;
        m_map = (m_map + 1) % NM;
        m_over = 1'b0;
        m_ready = 1'b0;
        chk("map_load_ready", ready, 0);
        chk("map_load_game_over", game_over, 0);
        chk("map_load_idx", map_idx, m_map);
        map_btn = 1'b0;
        tick();
        load_model(m_map);
        m_ready = 1'b1;
        check_state();
    endtask

    task automatic do_step(input int d, input bit rst_reloc, output bit ate);
        int nd, nx, ny, cx, cy;
        bit pre, ok;
        ate = 1'b0;
        pre = m_ready;
        dir = 2'(d);
        step = 1'b1;
        tick();
        step = 1'b0;
        if (pre) begin
            nd = eff_dir(d);
            m_dir = nd;
            nx = sx[0] + dxo(nd);
            ny = sy[0] + dyo(nd);
            if (is_border(nx, ny) || on_snake(nx, ny, sx.size() - 1)) begin
                m_over = 1'b1;
                m_ready = 1'b0;
            end else begin
                sx.push_front(nx);
                sy.push_front(ny);
                ate = (nx == ax) && (ny == ay);
                if (!ate || sx.size() > ML) begin
                    void'(sx.pop_back());
                    void'(sy.pop_back());
                end
                if (ate) begin
                    m_ready = 1'b0;
                    chk("ready_in_relocate", ready, 0);
                    if (rst_reloc) return;
                    ok = 1'b0;
                    for (int k = 0; k < 200 && !ok; k++) begin
                        cx = int'(m_lfsr[3:0]) + 1;
                        cy = int'(m_lfsr[7:4]) + 1;
                        ok = (cx <= GW - 2) && (cy <= GH - 2) && !on_snake(cx, cy, sx.size());
                        tick();
                        if (ok) begin
                            ax = cx;
                            ay = cy;
                            m_ready = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        bit ate, maxed, was_full, done;
        #2;
        do_reset();
        check_cell(0, 5);
        check_cell(15, 0);
        check_cell(4, 11);

        for (int i = 0; i < 4; i++) press_map(1'b0);

        for (int i = 0; i < 3; i++) begin
            do_step(0, 1'b0, ate);
            check_state();
        end

        do_reset();
        do_step(1, 1'b0, ate);
        check_state();
        for (int i = 0; i < 6; i++) begin
            do_step(2, 1'b0, ate);
            check_state();
        end
        press_map(1'b0);
        press_map(1'b1);

        maxed = 1'b0;
        for (int i = 0; i < 3000 && !maxed; i++) begin
            if (m_over) begin
                press_map(1'b0);
            end else begin
                was_full = (sx.size() == ML);
                do_step(pick_dir(), 1'b0, ate);
                check_state();
                if (ate && was_full) begin
                    maxed = 1'b1;
                    chk("length_capped", length, ML);
                end
            end
        end

        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (m_over) begin
                press_map(1'b0);
            end else begin
                do_step(pick_dir(), 1'b1, ate);
                if (ate) begin
                    do_reset();
                    done = 1'b1;
                end else begin
                    check_state();
                end
            end
        end

        for (int i = 0; i < 10; i++) begin
            if (m_over) press_map(1'b0);
            else do_step(pick_dir(), 1'b0, ate);
            check_state();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/snake_scene_gen.md
Name: snake_scene_gen

Overview:
Parametrised, stateful scene source for the grid display path. It holds snake segment positions, the apple position, the map index and the game-over state. It answers per-cell object queries (x,y) combinationally for image_generator. It replaces fixed per-map constants with multiple selectable start maps, a moving and growing snake, apple respawn and collision detection.

Parameters:
GRID_W, 16, grid columns; border at x=0 and x=GRID_W-1
GRID_H, 12, grid rows; border at y=0 and y=GRID_H-1
COORD_W, 4, coordinate width; must be 8 or less and 2^COORD_W must be at least max(GRID_W,GRID_H)
MAX_LEN, 8, maximum snake length in segments, head included; at least 4
NUM_MAPS, 4, number of start maps; NUM_MAPS+5 must be less than GRID_W-1

Ports:
clk  in  1  system clock (hwclk)
reset  in  1  reset, asynchronous, active-high
map_btn  in  1  raw pushbutton; internal 2-flop synchronizer plus rising-edge detect
step  in  1  one-cycle advance request; honoured only when ready=1
dir  in  2  00 right (x+1), 01 left (x-1), 10 up (y-1), 11 down (y+1)
x  in  COORD_W  query column
y  in  COORD_W  query row
border  out  1  query cell is a border cell
snake_head  out  1  query cell equals head position
snake_body  out  1  query cell equals any active non-head segment
apple  out  1  query cell equals apple position
ready  out  1  block accepts step this cycle
game_over  out  1  collision occurred; latched
map_idx  out  $clog2(NUM_MAPS)  current map
length  out  $clog2(MAX_LEN+1)  active segment count

Behaviour:
- Query outputs are purely combinational from x,y and registered state; zero latency. Only border is asserted for out-of-grid queries.
- Reset values: map_idx=0, game_over=0, ready=0, FSM=LOAD, LFSR=16'hACE1, cur_dir=00. Segment, apple and length registers load map 0 on the first LOAD cycle.
- Map k start state: head (3+k, GRID_H/3), body (2+k, GRID_H/3) and (1+k, GRID_H/3), length=3, apple (5+k+1, GRID_H/3), cur_dir=00.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every clock in all states.
- FSM states:
  - LOAD: load start state for map_idx; ready=0; go to RUN next cycle.
  - RUN: ready=1. On step, the sequence is:
    - If dir is the exact reverse of cur_dir, it is ignored and cur_dir is kept; otherwise cur_dir=dir.
    - Compute new head = head + cur_dir.
    - If new head is a border cell, or matches segments 0..length-2 (old tail excluded because it vacates), set game_over=1, freeze state and go to OVER.
    - Else segments shift: seg[i]<=seg[i-1] and seg[0]<=new head.
    - If new head equals apple: length<=min(length+1, MAX_LEN) and go to RELOCATE. On growth, the old tail becomes the last active segment.
  - RELOCATE: ready=0. Each cycle, candidate cx=L[COORD_W-1:0]+1 and cy=L[2*COORD_W-1:COORD_W]+1.
    - Accept when cx is at most GRID_W-2, cy is at most GRID_H-2, and the cell matches no active segment. Then write apple and go to RUN.
    - Otherwise retry next cycle.
  - OVER: ready=0, game_over=1. Only a map change or reset leaves it.
- Map change: a rising edge on the synchronized map_btn sets map_idx<=(map_idx==NUM_MAPS-1)?0:map_idx+1, clears game_over and enters LOAD from any state. A step in the same cycle is discarded.
- A step while ready=0 is ignored, not queued.
- Inactive segment registers (index of length or more) never assert snake_body.
- Reset mid-RELOCATE or mid-LOAD returns to the reset values immediately.

Test Plan:
- Reset then release; query (0,5), (15,0), (4,11) -> border=1. Query (3,4) -> snake_head=1. Query (2,4) and (1,4) -> snake_body=1. Query (6,4) -> apple=1. ready=1 from the 2nd cycle.
- Three map_btn presses held 4 cycles each -> map_idx 1,2,3 with head at (4,4),(5,4),(6,4). A 4th press -> map_idx=0, head (3,4).
- Map 0: step with dir=00 three times -> after the 3rd step head=(6,4), length=4, ready=0 for at least 1 cycle. The new apple lies in x 1..14, y 1..10 and not on the snake.
- Map 0: step with dir=01 -> reverse ignored, head moves to (4,4). Then step with dir=10 four times -> head y=0 on the 4th step: game_over=1, ready=0. Further steps leave the head unchanged.
- In OVER, a map_btn edge -> game_over=0, LOAD for 1 cycle, then RUN with map 1 start state. A map_btn edge coincident with step in RUN -> LOAD, and the step has no effect.
- Grow to MAX_LEN=8, eat once more -> length stays 8. Assert reset mid-RELOCATE -> outputs return to reset values asynchronously.
